// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM states, command codes, halt causes.
// No logic; widths here are fixed by the command and cause encodings.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_STEPPING = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_HALT  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_t;

  localparam int CAUSE_W = 3;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_CMD  = 3'd1,
    CAUSE_BP   = 3'd2,
    CAUSE_STEP = 3'd3,
    CAUSE_WDOG = 3'd4
  } cause_t;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Core/debugger-facing bundle of the run controller: PC watch, commands, status and counters.
// master = core + debug host side, slave = run_ctrl.
interface run_ctrl_if #(
  parameter int PC_W   = 16,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) ();
  import run_ctrl_pkg::*;

  localparam int IDX_W = idx_w(NUM_BP);

  logic [PC_W-1:0]        pc_next;
  logic                   instr_valid;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   cmd_valid;
  logic [1:0]             cmd;
  logic [STEP_W-1:0]      step_count;

  logic                   halt_req;
  logic                   halted;
  logic [CAUSE_W-1:0]     halt_cause;
  logic [IDX_W-1:0]       bp_hit_idx;
  logic [PC_W-1:0]        halt_pc;
  logic [CNT_W-1:0]       cycle_count;
  logic [CNT_W-1:0]       retire_count;

  modport master (
    output pc_next, instr_valid, bp_addr, bp_en, cmd_valid, cmd, step_count,
    input  halt_req, halted, halt_cause, bp_hit_idx, halt_pc, cycle_count, retire_count
  );

  modport slave (
    input  pc_next, instr_valid, bp_addr, bp_en, cmd_valid, cmd, step_count,
    output halt_req, halted, halt_cause, bp_hit_idx, halt_pc, cycle_count, retire_count
  );

endinterface

// File: rtl/run_ctrl_bp_match.sv
// bp_match: combinational priority comparator of pc against NUM_BP enabled breakpoint addresses.
// Zero latency; lowest matching channel index wins.
module bp_match #(
  parameter int NUM_BP = 4,
  parameter int PC_W   = 16,
  parameter int IDX_W  = 2
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] addr,
  input  logic [NUM_BP-1:0]      en,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan downwards so the last assignment left standing is the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (en[i] && (addr[i*PC_W +: PC_W] == pc)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: breakpoint/halt/single-step controller with saturating cycle and retire counters; idle watchdog under RUN_CTRL_WATCHDOG_EN.
// All status registered, 1-cycle response to hits and commands; no backpressure, commands are single-cycle strobes.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W       = 16,
  parameter int NUM_BP     = 4,
  parameter int CNT_W      = 32,
  parameter int STEP_W     = 8,
  parameter int WDOG_LIMIT = 1024
) (
  input logic     clk,
  input logic     rst,
  run_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_BP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  cause_t            cause, cause_nxt;
  logic [STEP_W-1:0] remain, remain_nxt;
  logic [PC_W-1:0]   halt_pc_q;
  logic [IDX_W-1:0]  hit_idx_q;
  logic [CNT_W-1:0]  cyc_q, ret_q;
  logic              bp_mask;
  logic              bp_hit, bp_take, bp_stop, wdog_fire;
  logic [IDX_W-1:0]  bp_idx;
  logic              is_run, is_halt, is_step, is_clear;

  assign is_run   = bus.cmd_valid && (bus.cmd == CMD_RUN);
  assign is_halt  = bus.cmd_valid && (bus.cmd == CMD_HALT);
  assign is_step  = bus.cmd_valid && (bus.cmd == CMD_STEP);
  assign is_clear = bus.cmd_valid && (bus.cmd == CMD_CLEAR);

  bp_match #(.NUM_BP(NUM_BP), .PC_W(PC_W), .IDX_W(IDX_W)) u_bp_match (
    .pc   (bus.pc_next),
    .addr (bus.bp_addr),
    .en   (bus.bp_en),
    .hit  (bp_hit),
    .idx  (bp_idx)
  );

  // After a resume, the breakpoint we stopped on stays masked until the PC moves off it.
  assign bp_take = bp_hit && !(bp_mask && (bus.pc_next == halt_pc_q));

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] idle_cnt;

  assign wdog_fire = (state == ST_RUNNING) && !bus.instr_valid &&
                     (idle_cnt == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if ((state == ST_RUNNING) && (state_nxt == ST_RUNNING) && !bus.instr_valid)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`else
  // The limit only matters when the watchdog is compiled in.
  assign wdog_fire = (WDOG_LIMIT < 0);
`endif

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    remain_nxt = remain;
    bp_stop    = 1'b0;
    case (state)
      ST_RUNNING: begin
        if (is_halt) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_CMD;
        end else if (bp_take) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_BP;
          bp_stop   = 1'b1;
        end else if (wdog_fire) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_WDOG;
        end
      end
      ST_STEPPING: begin
        if (is_halt) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_CMD;
        end else if (bus.instr_valid) begin
          remain_nxt = remain - 1'b1;
          if (remain == STEP_W'(1)) begin
            state_nxt = ST_HALTED;
            cause_nxt = CAUSE_STEP;
          end
        end
      end
      ST_HALTED: begin
        if (is_run) begin
          state_nxt = ST_RUNNING;
        end else if (is_step) begin
          state_nxt  = ST_STEPPING;
          remain_nxt = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;
        end
      end
      default: state_nxt = ST_RUNNING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUNNING;
      cause     <= CAUSE_NONE;
      remain    <= '0;
      halt_pc_q <= '0;
      hit_idx_q <= '0;
      bp_mask   <= 1'b0;
      cyc_q     <= '0;
      ret_q     <= '0;
    end else begin
      state  <= state_nxt;
      cause  <= cause_nxt;
      remain <= remain_nxt;
      if ((state != ST_HALTED) && (state_nxt == ST_HALTED))
        halt_pc_q <= bus.pc_next;
      if (bp_stop)
        hit_idx_q <= bp_idx;
      if ((state == ST_HALTED) && is_run)
        bp_mask <= 1'b1;
      else if ((state == ST_RUNNING) && (bus.pc_next != halt_pc_q))
        bp_mask <= 1'b0;
      if (is_clear) begin
        cyc_q <= '0;
        ret_q <= '0;
      end else if (state != ST_HALTED) begin
        if (cyc_q != CNT_MAX)
          cyc_q <= cyc_q + 1'b1;
        if (bus.instr_valid && (ret_q != CNT_MAX))
          ret_q <= ret_q + 1'b1;
      end
    end
  end

  assign bus.halt_req     = (state == ST_HALTED);
  assign bus.halted       = (state == ST_HALTED);
  assign bus.halt_cause   = cause;
  assign bus.bp_hit_idx   = hit_idx_q;
  assign bus.halt_pc      = halt_pc_q;
  assign bus.cycle_count  = cyc_q;
  assign bus.retire_count = ret_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios then random traffic, checked every cycle against a behavioural model.
// Watchdog expectations follow RUN_CTRL_WATCHDOG_EN, with WDOG_LIMIT = 8 and 8-bit counters to reach saturation.
module tb_run_ctrl;

  localparam int PC_W       = 16;
  localparam int NUM_BP     = 4;
  localparam int CNT_W      = 8;
  localparam int STEP_W     = 8;
  localparam int WDOG_LIMIT = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam logic [1:0] C_RUN = 2'd0, C_HALT = 2'd1, C_STEP = 2'd2, C_CLEAR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_ctrl_if #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .STEP_W(STEP_W)) bus ();

  run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .STEP_W(STEP_W),
             .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 = running, 1 = stepping, 2 = halted
  int m_state, m_cause, m_idx, m_pc, m_cyc, m_ret, m_rem, m_idle;
  bit m_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cause = 0; m_idx = 0; m_pc = 0;
    m_cyc = 0; m_ret = 0; m_rem = 0; m_idle = 0; m_mask = 1'b0;
  endtask

  task automatic model_halt(input int c, input int pc);
    m_state = 2;
    m_cause = c;
    m_pc    = pc;
  endtask

  task automatic model_step();
    int pc, hit, old;
    bit iv, hcmd, rcmd, scmd, clr, masked;
    pc   = int'(bus.pc_next);
    iv   = bus.instr_valid;
    hcmd = bus.cmd_valid && (bus.cmd == C_HALT);
    rcmd = bus.cmd_valid && (bus.cmd == C_RUN);
    scmd = bus.cmd_valid && (bus.cmd == C_STEP);
    clr  = bus.cmd_valid && (bus.cmd == C_CLEAR);
    hit  = -1;
    for (int i = 0; i < NUM_BP; i++)
      if (hit < 0 && bus.bp_en[i] && int'(bus.bp_addr[i*PC_W +: PC_W]) == pc) hit = i;
    old = m_state;
    if (clr) begin
      m_cyc = 0; m_ret = 0;
    end else if (old != 2) begin
      if (m_cyc < CNT_MAX) m_cyc++;
      if (iv && m_ret < CNT_MAX) m_ret++;
    end
    if (old == 0) begin
      masked = m_mask && (pc == m_pc);
      if (pc != m_pc) m_mask = 1'b0;
      if (hcmd) model_halt(1, pc);
      else if (hit >= 0 && !masked) begin
        model_halt(2, pc);
        m_idx = hit;
      end else if (WDOG_ON && !iv && (m_idle + 1 >= WDOG_LIMIT)) model_halt(4, pc);
      if (m_state == 0) m_idle = iv ? 0 : m_idle + 1;
      else m_idle = 0;
    end else if (old == 1) begin
      if (hcmd) model_halt(1, pc);
      else if (iv) begin
        m_rem--;
        if (m_rem == 0) model_halt(3, pc);
      end
    end else begin
      if (rcmd) begin
        m_state = 0; m_mask = 1'b1; m_idle = 0;
      end else if (scmd) begin
        m_state = 1;
        m_rem = (bus.step_count == 0) ? 1 : int'(bus.step_count);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".halted"},   bus.halted,       (m_state == 2));
    chk({tag, ".halt_req"}, bus.halt_req,     (m_state == 2));
    chk({tag, ".cause"},    bus.halt_cause,   m_cause);
    chk({tag, ".idx"},      bus.bp_hit_idx,   m_idx);
    chk({tag, ".halt_pc"},  bus.halt_pc,      m_pc);
    chk({tag, ".cycles"},   bus.cycle_count,  m_cyc);
    chk({tag, ".retires"},  bus.retire_count, m_ret);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input logic [1:0] c, input string tag);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick(tag);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic set_bp(input int ch, input int addr);
    bus.bp_addr[ch*PC_W +: PC_W] = PC_W'(addr);
  endtask

  initial begin
    bus.pc_next = '0; bus.instr_valid = 1'b0; bus.bp_addr = '0; bus.bp_en = '0;
    bus.cmd_valid = 1'b0; bus.cmd = C_RUN; bus.step_count = '0;
    model_reset();
    #12;
    chk("reset.halt_req", bus.halt_req, 0);
    chk("reset.cause", bus.halt_cause, 0);
    chk("reset.cycles", bus.cycle_count, 0);
    rst = 1'b0;

    // Breakpoint at 50 on channel 0
    set_bp(0, 50);
    bus.bp_en = 4'b0001;
    bus.instr_valid = 1'b1;
    for (int pc = 0; pc <= 50; pc++) begin
      bus.pc_next = PC_W'(pc);
      tick("bp50");
      if (pc < 50) chk("bp50.pre", bus.halt_req, 0);
    end
    chk("bp50.halt_req", bus.halt_req, 1);
    chk("bp50.cause", bus.halt_cause, 2);
    chk("bp50.idx", bus.bp_hit_idx, 0);
    chk("bp50.pc", bus.halt_pc, 50);

    // Resume on the breakpoint: no re-halt until PC leaves and comes back
    send(C_RUN, "resume");
    chk("resume.halt_req", bus.halt_req, 0);
    for (int k = 0; k < 3; k++) tick("resume.hold");
    chk("resume.nohalt", bus.halt_req, 0);
    for (int pc = 51; pc < 54; pc++) begin
      bus.pc_next = PC_W'(pc);
      tick("resume.move");
    end
    bus.pc_next = PC_W'(50);
    tick("rehit");
    chk("rehit.halt_req", bus.halt_req, 1);
    chk("rehit.cause", bus.halt_cause, 2);

    // Channels 1 and 3 both at 20: lowest wins
    set_bp(1, 20); set_bp(3, 20);
    bus.bp_en = 4'b1010;
    send(C_RUN, "prio.run");
    bus.pc_next = PC_W'(20);
    tick("prio");
    chk("prio.idx", bus.bp_hit_idx, 1);
    chk("prio.pc", bus.halt_pc, 20);

    // Step 3 with a retire gap, then step 0
    bus.instr_valid = 1'b0;
    bus.step_count = 8'd3;
    send(C_STEP, "step3.go");
    chk("step3.running", bus.halt_req, 0);
    bus.pc_next = PC_W'(21); bus.instr_valid = 1'b1; tick("step3.r1");
    bus.instr_valid = 1'b0; tick("step3.gap");
    bus.pc_next = PC_W'(22); bus.instr_valid = 1'b1; tick("step3.r2");
    chk("step3.r2_running", bus.halted, 0);
    bus.pc_next = PC_W'(23); tick("step3.r3");
    chk("step3.done", bus.halted, 1);
    chk("step3.cause", bus.halt_cause, 3);
    bus.instr_valid = 1'b0;
    bus.step_count = 8'd0;
    send(C_STEP, "step0.go");
    bus.instr_valid = 1'b1; tick("step0.r1");
    chk("step0.done", bus.halted, 1);
    chk("step0.cause", bus.halt_cause, 3);

    // CLEAR wins over a same-cycle increment
    bus.bp_en = '0;
    send(C_RUN, "clr.run");
    for (int k = 0; k < 3; k++) tick("clr.pre");
    send(C_CLEAR, "clr");
    chk("clr.cycles", bus.cycle_count, 0);
    chk("clr.retires", bus.retire_count, 0);

    // Saturation
    for (int k = 0; k < CNT_MAX + 40; k++) tick("sat");
    chk("sat.cycles", bus.cycle_count, CNT_MAX);
    chk("sat.retires", bus.retire_count, CNT_MAX);

    // Idle run: watchdog fires after exactly WDOG_LIMIT idle cycles when built in
    bus.instr_valid = 1'b0;
    for (int k = 1; k <= WDOG_LIMIT; k++) begin
      tick("wdog");
      if (k < WDOG_LIMIT) chk("wdog.pre", bus.halted, 0);
    end
`ifdef RUN_CTRL_WATCHDOG_EN
    chk("wdog.halted", bus.halted, 1);
    chk("wdog.cause", bus.halt_cause, 4);
`else
    chk("wdog.off", bus.halted, 0);
`endif

    // Random traffic
    for (int i = 0; i < NUM_BP; i++) set_bp(i, $urandom_range(0, 15));
    bus.bp_en = NUM_BP'($urandom_range(0, 15));
    for (int k = 0; k < 2500; k++) begin
      bus.pc_next     = PC_W'($urandom_range(0, 15));
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_valid   = ($urandom_range(0, 7) == 0);
      bus.cmd         = 2'($urandom_range(0, 3));
      bus.step_count  = STEP_W'($urandom_range(0, 4));
      if (k % 500 == 499) bus.bp_en = NUM_BP'($urandom_range(0, 15));
      tick("rand");
    end
    bus.cmd_valid = 1'b0;

    // Async reset in the middle of a step sequence
    send(C_HALT, "arst.halt");
    bus.step_count = 8'd5;
    send(C_STEP, "arst.step");
    bus.instr_valid = 1'b1;
    tick("arst.r1");
    chk("arst.stepping", bus.halted, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.halt_req", bus.halt_req, 0);
    chk("arst.cause", bus.halt_cause, 0);
    chk("arst.cycles", bus.cycle_count, 0);
    chk("arst.retires", bus.retire_count, 0);
    chk("arst.pc", bus.halt_pc, 0);
    #1 rst = 1'b0;
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick("arst.after");
    chk("arst.running", bus.halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
